// File: rtl/mdc_arbiter.sv
// Two-requester front end for a shared iterative Euclidean GCD datapath.
// Round-robin grant, one modulus step per clock, req/ack/done handshake per requester.
module mdc_arbiter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    output logic         ack0,
    output logic         done0,
    output logic [W-1:0] g0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack1,
    output logic         done1,
    output logic [W-1:0] g1,
    output logic         busy
);

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         owner_q;
    logic         last_q;
    logic         grant0;
    logic         grant1;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        grant0 = req0 && (!req1 || last_q);
        grant1 = req1 && !grant0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            g0      <= '0;
            g1      <= '0;
            busy    <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        a_q     <= grant0 ? a0 : a1;
                        b_q     <= grant0 ? b0 : b1;
                        owner_q <= grant1;
                        ack0    <= grant0;
                        ack1    <= grant1;
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (b_q != '0) begin
                        a_q <= b_q;
                        b_q <= a_q % b_q;
                    end else begin
                        if (owner_q) begin
                            g1    <= a_q;
                            done1 <= 1'b1;
                        end else begin
                            g0    <= a_q;
                            done0 <= 1'b1;
                        end
                        last_q  <= owner_q;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdc_arbiter.sv
// Bench for mdc_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mdc_arbiter;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, done0, done1, busy;
    logic [W-1:0] g0, g1;

    int vectors = 0;
    int miscompares = 0;

    mdc_arbiter #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .a0   (a0),
        .b0   (b0),
        .ack0 (ack0),
        .done0(done0),
        .g0   (g0),
        .req1 (req1),
        .a1   (a1),
        .b1   (b1),
        .ack1 (ack1),
        .done1(done1),
        .g1   (g1),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole transactions, result and step count worked out at grant time.
    bit           m_valid = 1'b0;
    logic         m_ack[2];
    logic         m_done[2];
    logic [W-1:0] m_g[2];
    logic         m_busy, m_last, m_owner;
    logic [W-1:0] m_res;
    int           m_cnt;

    function automatic void euclid(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] g, output int steps);
        logic [W-1:0] t;
        steps = 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            steps++;
        end
        g = x;
    endfunction

    always @(posedge clk) begin
        int           k;
        int           gi;
        logic [W-1:0] ga, gb;
        if (rst) begin
            m_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_ack[i]  = 1'b0;
                m_done[i] = 1'b0;
                m_g[i]    = '0;
            end
            m_last = 1'b1;
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                m_ack[i]  = 1'b0;
                m_done[i] = 1'b0;
            end
            if (!m_busy) begin
                gi = -1;
                if (req0 && req1) gi = m_last ? 0 : 1;
                else if (req0)    gi = 0;
                else if (req1)    gi = 1;
                if (gi >= 0) begin
                    ga = (gi == 0) ? a0 : a1;
                    gb = (gi == 0) ? b0 : b1;
                    euclid(ga, gb, m_res, k);
                    m_cnt     = k + 1;
                    m_owner   = gi[0];
                    m_ack[gi] = 1'b1;
                    m_busy    = 1'b1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done[m_owner] = 1'b1;
                    m_g[m_owner]    = m_res;
                    m_last          = m_owner;
                    m_busy          = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ack0", ack0, m_ack[0]);
            check("ack1", ack1, m_ack[1]);
            check("done0", done0, m_done[0]);
            check("done1", done1, m_done[1]);
            check("g0", g0, m_g[0]);
            check("g1", g1, m_g[1]);
            check("busy", busy, m_busy);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // One full transaction; operands switch to na/nb right after the ack.
    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] na, input logic [W-1:0] nb, output int edges);
        int n = 0;
        if (idx == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; a1 = a; b1 = b; end
        do begin
            @(negedge clk);
            n++;
        end while (((idx == 0) ? ack0 : ack1) !== 1'b1 && n < 100);
        check("issue_ack", (idx == 0) ? ack0 : ack1, 1);
        if (idx == 0) begin req0 = 1'b0; a0 = na; b0 = nb; end
        else          begin req1 = 1'b0; a1 = na; b1 = nb; end
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (((idx == 0) ? done0 : done1) !== 1'b1 && edges < 100);
        check("issue_done", (idx == 0) ? done0 : done1, 1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1, 2:    return W'($urandom_range(1, 40));
            default: return W'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        int edges;
        int first, prev, grants, t_ack1, t_done1;
        bit seen0;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_g0", g0, 0);
        check("rst_g1", g1, 0);
        check("rst_ack0", ack0, 0);
        check("rst_done1", done1, 0);
        rst = 1'b0;

        // gcd(8,2): one step, done two edges after capture
        issue(0, 16'd8, 16'd2, 16'd8, 16'd2, edges);
        check("t1_latency", edges, 2);
        check("t1_g0", g0, 2);
        @(negedge clk);
        check("t1_busy_after", busy, 0);

        // Simultaneous requests straight after reset
        do_reset();
        req0 = 1'b1; a0 = 16'd15; b0 = 16'd3;
        req1 = 1'b1; a1 = 16'd15; b1 = 16'd2;
        first = -1; t_ack1 = -1; t_done1 = -1; seen0 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin
                if (first < 0) first = 0;
                req0 = 1'b0;
            end
            if (ack1 === 1'b1) begin
                if (first < 0) first = 1;
                req1 = 1'b0;
                t_ack1 = c;
            end
            if (done0 === 1'b1) begin
                seen0 = 1'b1;
                check("t2_g0", g0, 3);
            end
            if (done1 === 1'b1) begin
                t_done1 = c;
                check("t2_g1", g1, 1);
            end
            if (seen0) check("t2_g0_hold", g0, 3);
        end
        check("t2_first_grant", first, 0);
        check("t2_done1_latency", t_done1 - t_ack1, 3);

        // Continuous contention must alternate
        req0 = 1'b1; a0 = 16'd12; b0 = 16'd8;
        req1 = 1'b1; a1 = 16'd9;  b1 = 16'd6;
        prev = -1; grants = 0;
        for (int c = 0; c < 200 && grants < 6; c++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                if (prev >= 0) check("t3_alternate", ack1, (prev == 0) ? 1 : 0);
                prev = (ack1 === 1'b1) ? 1 : 0;
                grants++;
            end
        end
        check("t3_grant_count", grants, 6);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Zero operands
        issue(0, 16'd170, 16'd0, 16'd0, 16'd0, edges);
        check("t4_x0_latency", edges, 1);
        check("t4_x0_g0", g0, 170);
        issue(0, 16'd0, 16'd0, 16'd0, 16'd0, edges);
        check("t4_00_g0", g0, 0);
        issue(0, 16'd0, 16'd12, 16'd0, 16'd0, edges);
        check("t4_0y_latency", edges, 2);
        check("t4_0y_g0", g0, 12);

        // Reset during CALC aborts the computation
        do_reset();
        req1 = 1'b1; a1 = 16'd170; b1 = 16'd4;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (ack1 !== 1'b1 && edges < 100);
        check("t5_ack1", ack1, 1);
        req1 = 1'b0;
        @(negedge clk);
        check("t5_busy_calc", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_g1", g1, 0);
        repeat (5) begin
            @(negedge clk);
            check("t5_no_done1", done1, 0);
        end
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'd6; b0 = 16'd4; a1 = 16'd10; b1 = 16'd5;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (ack0 !== 1'b1 && ack1 !== 1'b1 && edges < 100);
        check("t5_first_ack0", ack0, 1);
        check("t5_first_ack1", ack1, 0);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Operands changed after capture are ignored
        issue(0, 16'd1071, 16'd462, 16'd5, 16'd7, edges);
        check("t6_latency", edges, 4);
        check("t6_g0", g0, 21);
        @(negedge clk);

        // Random traffic with occasional withdrawals, re-requests and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req0 && m_ack[0])  req0 = ($urandom_range(0, 3) == 0);
            else if (req0)         req0 = ($urandom_range(0, 15) != 0);
            else                   req0 = ($urandom_range(0, 3) == 0);
            if (req1 && m_ack[1])  req1 = ($urandom_range(0, 3) == 0);
            else if (req1)         req1 = ($urandom_range(0, 15) != 0);
            else                   req1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin a0 = rnd_op(); b0 = rnd_op(); end
            if ($urandom_range(0, 1) == 0) begin a1 = rnd_op(); b1 = rnd_op(); end
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdc_arbiter.md
Name: mdc_arbiter

Overview:
- Shares one iterative Euclidean GCD datapath between two requesters.
- Each requester presents an operand pair with a req/ack/done handshake.
- Arbitration between requesters is round-robin.
- The datapath performs one modulus step per clock, replacing the single-cycle combinational GCD in timing-critical paths.

Parameters:
W  16  operand and result width in bits

Ports:
clk    input   1  system clock, all state updates on rising edge
rst    input   1  synchronous active-high reset
req0   input   1  requester 0 request, held high until ack0
a0     input   W  requester 0 first operand
b0     input   W  requester 0 second operand
ack0   output  1  one-cycle pulse, requester 0 operands captured
done0  output  1  one-cycle pulse, g0 valid with new result
g0     output  W  requester 0 result, held until its next completion
req1   input   1  requester 1 request
a1     input   W  requester 1 first operand
b1     input   W  requester 1 second operand
ack1   output  1  requester 1 capture pulse
done1  output  1  requester 1 completion pulse
g1     output  W  requester 1 result
busy   output  1  high while a computation is in progress

Behaviour:
Reset:
- Synchronous, active-high, on clk rising edge.
- ack0, ack1, done0, done1, busy, g0 and g1 all become 0.
- State becomes IDLE.
- Round-robin pointer `last` becomes 1, so requester 0 wins the first tie.
- rst asserted mid-computation aborts it: no done pulse, no g update.

Internal registers:
- A, B (W bits), owner (1 bit), last (1 bit).

FSM states: IDLE, CALC.

IDLE:
- No req high: stay in IDLE, busy=0.
- Exactly one req high: grant that requester.
- Both req high: grant the requester != last.
- On the grant edge:
  - A<=a_i, B<=b_i, owner<=i.
  - ack_i<=1 for exactly one cycle; busy<=1.
  - Go to CALC.

CALC, per edge:
- B!=0: A<=B, B<=A%B (unsigned, W bits). Stay in CALC.
- B==0:
  - g_owner<=A, done_owner<=1 for one cycle.
  - last<=owner, busy<=0.
  - Go to IDLE.

Latency:
- Capture edge E; k = number of modulus steps until B==0.
- done fires on edge E+k+1.
- Earliest next grant is the edge after done; no back-to-back overlap.

Boundary conditions:
- gcd(x,0)=x; gcd(0,0)=0; gcd(0,y)=y (one step).
- Result width is W; no overflow is possible.

Operand sampling:
- a_i and b_i are sampled only on the grant edge; later changes are ignored.

Request rules:
- req_i still high in the cycle after ack_i counts as a new request.
- Requesters must drop req the cycle ack is seen, unless they want another computation.
- req_i falling before ack_i withdraws the request; nothing is recorded.

Other rules:
- A requester not granted is never acked or done-pulsed.
- g of the other requester holds its value.
- At most one of ack0/ack1 is high per cycle; same for done0/done1.
- ack and done never coincide.

Test Plan:
1. Reset, then req0=1, a0=8, b0=2 (capture edge E): ack0=1 after E; E+1 gives A=2, B=0; done0=1 and g0=2 after E+2; busy low afterwards.
2. req0 (a0=15, b0=3) and req1 (a1=15, b1=2) raised in the same cycle after reset: ack0 first, g0=3 with done0; then ack1, g1=1 with done1 three edges after its capture; g0 stays 3 throughout.
3. req0 and req1 held continuously with fixed operands: grants alternate 0,1,0,1 for at least 4 grants; no requester is granted twice in a row while the other waits.
4. Zero operands on req0: a0=170, b0=0 gives g0=170, done one edge after capture; a0=0, b0=0 gives g0=0; a0=0, b0=12 gives g0=12 after one step.
5. req1 with a1=170, b1=4; assert rst for one cycle during CALC: no done1; g1=0, busy=0. A following simultaneous req0/req1 grants requester 0 first.
6. a0 and b0 changed during CALC (request 1071, 462, then change to 5, 7): g0=21 regardless of the change.
